int_to_ascii_stream: RTL and testbench
======================================

# int_to_ascii_stream

Sequential, parametrised signed-integer-to-ASCII formatter. Takes a WIDTH-bit two's-complement value over a valid/ready handshake. Converts it to BCD with a serial double-dabble engine. Emits the decimal text one ASCII character per cycle on a valid/ready byte stream that feeds the UART/display text path. It supersedes the fixed 3-digit combinational converter: any width, optional zero padding, optional '+' sign, optional line terminator, and back-pressure.

## Interface
- WIDTH, 32, input value width in bits (≥ 2)
- DIGITS, 10, BCD digit count; must be ≥ ceil(WIDTH·log10 2) (elaboration error otherwise)
- SIGN_PLUS, 0, 1 = emit '+' before non-negative values; 0 = no sign character for them
- TERM_EN, 1, 1 = append TERM_CHAR after the last digit
- TERM_CHAR, 8'h0A, terminator byte
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request carries a value
- in_ready  out  1  block can accept a request
- in_value  in  WIDTH  signed two's-complement value
- in_zero_pad  in  1  1 = print all DIGITS digits with leading zeros (sampled with in_value)
- out_valid  out  1  out_char is valid
- out_ready  in  1  consumer accepts out_char
- out_char  out  8  ASCII byte
- out_last  out  1  marks the final byte of the string
- busy  out  1  a request is in progress (state ≠ IDLE)

## Operation
- States: IDLE → CONVERT → SIGN → DIGIT → TERM → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, capture neg = in_value[WIDTH-1] and in_zero_pad.
  - Capture mag = neg ? -in_value : in_value, computed as WIDTH-bit unsigned. The most-negative value yields 2^(WIDTH-1) correctly.
  - Clear the BCD register (4·DIGITS bits) and the bit counter, then go to CONVERT.
- CONVERT:
  - Runs exactly WIDTH cycles.
  - Each cycle: every nibble ≥ 5 gets +3, then {bcd, mag} shifts left by 1.
  - After the last shift, load the digit pointer.
    - in_zero_pad = 1: pointer = DIGITS-1.
    - Otherwise: pointer = index of the most-significant non-zero nibble, or 0 if the value is zero. This uses a single-cycle priority encode with no extra cycles.
  - Next state is SIGN if neg or SIGN_PLUS, else DIGIT.
- SIGN: out_char = '-' if neg, else '+'.
- DIGIT:
  - out_char = 8'h30 + bcd[pointer].
  - When the byte transfers, decrement the pointer. After pointer 0 transfers, go to TERM if TERM_EN, else IDLE.
- TERM: out_char = TERM_CHAR; go to IDLE when it transfers.
- out_last is 1 on the final byte: the terminator if TERM_EN, else digit 0.
- A byte transfers when out_valid && out_ready. While out_valid && !out_ready, out_char and out_last hold stable. out_valid never drops without a transfer.
- Zero always prints "0", never a sign unless SIGN_PLUS. Zero with padding prints DIGITS zeros.
- Reset at any time: async return to IDLE, discard the current request, and drive all outputs to their reset values. No partial string resumes.

## Timing
- Reset values: in_ready 0 while reset is asserted and 1 from the first cycle after release. out_valid, out_char, out_last, busy are all 0.
- Request accepted at edge T. CONVERT occupies T+1 … T+WIDTH. First byte has out_valid = 1 in cycle T+WIDTH+1.
- With out_ready held high, one byte per cycle; no bubbles between SIGN, DIGIT and TERM.
- in_ready goes 0 the cycle after acceptance. It returns to 1 the cycle after the last byte transfers. No request is accepted during the final-byte transfer cycle.
- Total occupancy with no back-pressure = 1 + WIDTH + bytes emitted.

## Structure
- Package ascii_fmt_pkg:
  - state enum;
  - ASCII constants: '0' = 8'h30, '-' = 8'h2D, '+' = 8'h2B;
  - function min_digits(width) for the DIGITS check.
- Sub-module bcd_add3: combinational 4-bit nibble correction (≥ 5 → +3), instantiated DIGITS times via generate.
- Everything else lives in one module.

## Test plan
- WIDTH=32, no pad, in_value=42, out_ready=1 → bytes "4","2",0x0A. out_last on 0x0A. First out_valid 33 cycles after acceptance.
- in_value=-100 → "-","1","0","0",0x0A. in_value=0 → "0",0x0A.
- in_value=-2147483648 → "-2147483648",0x0A. in_value=2147483647 → "2147483647",0x0A.
- in_zero_pad=1, in_value=7 → "0000000007",0x0A. SIGN_PLUS=1, in_value=5 → "+","5",0x0A.
- Back-pressure: random out_ready with 30% duty, in_value=-9876 → same bytes "-9876\n", out_char stable while stalled. in_valid held high during busy is ignored until in_ready.
- Reset asserted mid-DIGIT, after 2 bytes of "12345" → outputs zero immediately. After release, a new request 99 yields "99",0x0A with no leftover bytes.

Source files
------------

// File: rtl/int_to_ascii_stream_pkg.sv
// Shared types and constants for the signed-integer-to-ASCII text formatter.
package ascii_fmt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      SIGN,
      DIGIT,
      TERM
   } state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;

   // ceil(width * log10(2)) in fixed point; width * log10(2) is never an integer for width > 0
   function automatic int min_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/int_to_ascii_stream_if.sv
// Request stream (value in) and byte stream (text out) of the ASCII formatter.
interface int_to_ascii_stream_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_value;
   logic             in_zero_pad;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_char;
   logic             out_last;

   modport master (
      output in_valid, in_value, in_zero_pad, out_ready,
      input  in_ready, out_valid, out_char, out_last
   );

   modport slave (
      input  in_valid, in_value, in_zero_pad, out_ready,
      output in_ready, out_valid, out_char, out_last
   );
endinterface

// File: rtl/int_to_ascii_stream_bcd_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/int_to_ascii_stream.sv
// Signed integer to decimal ASCII formatter: serial double-dabble, then one
// character per cycle (sign, digits, terminator) on a valid/ready byte stream.
module int_to_ascii_stream
   import ascii_fmt_pkg::*;
#(
   parameter int         WIDTH     = 32,
   parameter int         DIGITS    = 10,
   parameter bit         SIGN_PLUS = 1'b0,
   parameter bit         TERM_EN   = 1'b1,
   parameter logic [7:0] TERM_CHAR = 8'h0A
) (
   input  logic                   clock,
   input  logic                   reset,
   int_to_ascii_stream_if.slave   bus,
   output logic                   busy
);

   localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(WIDTH + 1);

   if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
      $error("int_to_ascii_stream: DIGITS is too small to hold every WIDTH-bit magnitude");
   end

   state_t                 state, state_nx;
   logic                   rdy_q;
   logic                   neg, zpad;
   logic [WIDTH-1:0]       mag, mag_nx;
   logic [DIGITS-1:0][3:0] bcd, bcd_adj, bcd_nx;
   logic [CW-1:0]          cnt;
   logic [PW-1:0]          ptr, msd;
   logic                   accept, xfer, conv_last;

   assign accept    = bus.in_valid && rdy_q;
   assign xfer      = bus.out_valid && bus.out_ready;
   assign conv_last = (cnt == CW'(WIDTH - 1));

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (.d(bcd[i]), .q(bcd_adj[i]));
   end

   assign {bcd_nx, mag_nx} = {bcd_adj, mag} << 1;

   // Leading-digit index taken from the post-shift value so the pointer loads on the final shift
   always_comb begin
      msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_nx[i] != 4'd0) msd = PW'(i);
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         rdy_q <= 1'b0;
      end else begin
         state <= state_nx;
         rdy_q <= (state_nx == IDLE);
      end
   end

   // NOTE: every output of a combinational block is defaulted first so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = CONVERT;
         CONVERT: if (conv_last) state_nx = (neg || SIGN_PLUS) ? SIGN : DIGIT;
         SIGN:    if (bus.out_ready) state_nx = DIGIT;
         DIGIT:   if (bus.out_ready && ptr == '0) state_nx = TERM_EN ? TERM : IDLE;
         TERM:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = rdy_q;
      bus.out_valid = 1'b0;
      bus.out_char  = 8'h00;
      bus.out_last  = 1'b0;
      busy          = (state != IDLE);
      case (state)
         SIGN: begin
            bus.out_valid = 1'b1;
            bus.out_char  = neg ? ASCII_MINUS : ASCII_PLUS;
         end
         DIGIT: begin
            bus.out_valid = 1'b1;
            bus.out_char  = ASCII_ZERO + {4'd0, bcd[ptr]};
            bus.out_last  = !TERM_EN && (ptr == '0);
         end
         TERM: begin
            bus.out_valid = 1'b1;
            bus.out_char  = TERM_CHAR;
            bus.out_last  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         neg  <= 1'b0;
         zpad <= 1'b0;
         mag  <= '0;
         bcd  <= '0;
         cnt  <= '0;
         ptr  <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               neg  <= bus.in_value[WIDTH-1];
               zpad <= bus.in_zero_pad;
               // Unsigned negation maps the most-negative input to 2^(WIDTH-1)
               mag  <= bus.in_value[WIDTH-1] ? -bus.in_value : bus.in_value;
               bcd  <= '0;
               cnt  <= '0;
            end
            CONVERT: begin
               bcd <= bcd_nx;
               mag <= mag_nx;
               cnt <= cnt + 1'b1;
               if (conv_last) ptr <= zpad ? PW'(DIGITS - 1) : msd;
            end
            DIGIT: if (xfer) ptr <= ptr - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_ascii_stream.sv
// Scoreboard bench: two formatter instances (plain sign and '+' sign) driven with
// directed and random values, expected text derived from decimal printing.
module tb_int_to_ascii_stream;

   localparam int WIDTH = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [1:0]            in_valid_a, in_zero_pad_a, out_ready_a;
   logic [1:0][WIDTH-1:0] in_value_a;
   logic [1:0]            in_ready_a, out_valid_a, out_last_a, busy_a;
   logic [1:0][7:0]       out_char_a;

   logic [8:0] exp_q [2][$];
   int         xfer_cnt [2];
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         bp_mode  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      int_to_ascii_stream_if #(.WIDTH(WIDTH)) bus ();

      assign bus.in_valid    = in_valid_a[g];
      assign bus.in_value    = in_value_a[g];
      assign bus.in_zero_pad = in_zero_pad_a[g];
      assign bus.out_ready   = out_ready_a[g];
      assign in_ready_a[g]   = bus.in_ready;
      assign out_valid_a[g]  = bus.out_valid;
      assign out_char_a[g]   = bus.out_char;
      assign out_last_a[g]   = bus.out_last;

      int_to_ascii_stream #(
         .WIDTH(WIDTH), .DIGITS(10), .SIGN_PLUS(g == 1), .TERM_EN(1'b1), .TERM_CHAR(8'h0A)
      ) dut (
         .clock(clock), .reset(reset), .bus(bus), .busy(busy_a[g])
      );

      // Monitor: pops the scoreboard on every transfer, checks hold-while-stalled
      initial begin : mon
         logic [8:0] held, e;
         bit         stalled;
         stalled = 1'b0;
         held    = '0;
         forever begin
            @(negedge clock);
            if (reset) begin
               stalled = 1'b0;
            end else begin
               if (stalled) begin
                  check($sformatf("u%0d.hold_valid", g), 32'(bus.out_valid), 32'd1);
                  check($sformatf("u%0d.hold_byte", g), {23'd0, bus.out_last, bus.out_char}, {23'd0, held});
               end
               stalled = 1'b0;
               if (bus.out_valid) begin
                  if (!bus.out_ready) begin
                     stalled = 1'b1;
                     held    = {bus.out_last, bus.out_char};
                  end else begin
                     xfer_cnt[g]++;
                     if (exp_q[g].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL u%0d.unexpected_byte: got 0x%0h, expected no byte", g, bus.out_char);
                     end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("u%0d.char", g), 32'(bus.out_char), 32'(e[7:0]));
                        check($sformatf("u%0d.last", g), 32'(bus.out_last), 32'(e[8]));
                     end
                  end
               end
            end
         end
      end
   end

   // Reference: plain decimal printing of the signed value
   function automatic void push_expected(input int k, input logic [31:0] v, input bit pad);
      longint m;
      string  s, ds;
      m = longint'(signed'(v));
      s = "";
      if (m < 0) s = "-";
      else if (k == 1) s = "+";
      if (m < 0) m = -m;
      ds = $sformatf("%0d", m);
      if (pad) while (ds.len() < 10) ds = {"0", ds};
      s = {s, ds};
      for (int i = 0; i < s.len(); i++) exp_q[k].push_back({1'b0, s[i]});
      exp_q[k].push_back({1'b1, 8'h0A});
   endfunction

   task automatic send(input int k, input logic [31:0] v, input bit pad, input bit keep);
      bit ok;
      ok = 1'b0;
      push_expected(k, v, pad);
      in_value_a[k]    = v;
      in_zero_pad_a[k] = pad;
      in_valid_a[k]    = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clock);
         if (in_ready_a[k]) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("u%0d.accept_in_time", k), 32'(ok), 32'd1);
      @(posedge clock);
      #1;
      if (!keep) in_valid_a[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clock);
         if (exp_q[k].size() == 0 && !busy_a[k] && !in_valid_a[k]) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("u%0d.drained", k), 32'(ok), 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         for (int k = 0; k < 2; k++)
            out_ready_a[k] = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         lat, base, k, k_next, sel;
      bit         ok, keep, pad;
      logic [31:0] v;
      logic [31:0] edge_vals [8];

      edge_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000,
                    32'h7FFF_FFFF, 32'd9, 32'd10, 32'hFFFF_FFF6};

      in_valid_a    = '0;
      in_zero_pad_a = '0;
      in_value_a    = '0;
      out_ready_a   = 2'b11;
      reset         = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d.rst_in_ready", i), 32'(in_ready_a[i]), 32'd0);
         check($sformatf("u%0d.rst_out_valid", i), 32'(out_valid_a[i]), 32'd0);
         check($sformatf("u%0d.rst_out_char", i), 32'(out_char_a[i]), 32'd0);
         check($sformatf("u%0d.rst_out_last", i), 32'(out_last_a[i]), 32'd0);
         check($sformatf("u%0d.rst_busy", i), 32'(busy_a[i]), 32'd0);
      end
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      for (int i = 0; i < 2; i++)
         check($sformatf("u%0d.ready_after_reset", i), 32'(in_ready_a[i]), 32'd1);
      @(posedge clock);
      #1;

      // Directed values, no back-pressure
      send(0, 32'd42, 1'b0, 1'b0);
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         lat++;
         if (i == 0) check("u0.in_ready_low_after_accept", 32'(in_ready_a[0]), 32'd0);
         if (out_valid_a[0]) break;
      end
      check("u0.first_byte_latency", 32'(lat), 32'(WIDTH + 1));
      wait_idle(0);

      send(0, -32'sd100, 1'b0, 1'b0);
      send(0, 32'd0, 1'b0, 1'b0);
      send(0, 32'h8000_0000, 1'b0, 1'b0);
      send(0, 32'h7FFF_FFFF, 1'b0, 1'b0);
      send(0, 32'd7, 1'b1, 1'b0);
      send(0, 32'd0, 1'b1, 1'b0);
      send(1, 32'd5, 1'b0, 1'b0);
      send(1, 32'd0, 1'b0, 1'b0);
      send(1, -32'sd3, 1'b1, 1'b0);
      wait_idle(0);
      wait_idle(1);

      // Back-pressure and in_valid held across a busy period
      bp_mode = 1'b1;
      send(0, -32'sd9876, 1'b0, 1'b0);
      send(0, 32'd31, 1'b0, 1'b1);
      send(0, -32'sd5, 1'b0, 1'b0);
      wait_idle(0);

      // Random traffic on both instances
      k_next = $urandom_range(0, 1);
      for (int n = 0; n < 40; n++) begin
         k      = k_next;
         k_next = $urandom_range(0, 1);
         keep   = (k_next == k) && ($urandom_range(0, 3) == 0) && (n != 39);
         bp_mode = $urandom_range(0, 1);
         pad    = ($urandom_range(0, 3) == 0);
         sel    = $urandom_range(0, 2);
         if (sel == 0) begin
            v = $urandom;
         end else if (sel == 1) begin
            v = $urandom_range(0, 999);
            if ($urandom_range(0, 1) == 1) v = -v;
         end else begin
            v = edge_vals[$urandom_range(0, 7)];
         end
         send(k, v, pad, keep);
      end
      wait_idle(0);
      wait_idle(1);

      // Reset in the middle of the digit phase
      bp_mode = 1'b0;
      @(posedge clock);
      #1;
      base = xfer_cnt[0];
      send(0, 32'd12345, 1'b0, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         #1;
         if (xfer_cnt[0] == base + 2) begin
            ok = 1'b1;
            break;
         end
      end
      check("u0.reached_digit_phase", 32'(ok), 32'd1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("u0.midrst_out_valid", 32'(out_valid_a[0]), 32'd0);
      check("u0.midrst_out_char", 32'(out_char_a[0]), 32'd0);
      check("u0.midrst_out_last", 32'(out_last_a[0]), 32'd0);
      check("u0.midrst_busy", 32'(busy_a[0]), 32'd0);
      check("u0.midrst_in_ready", 32'(in_ready_a[0]), 32'd0);
      exp_q[0].delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("u0.ready_after_midrst", 32'(in_ready_a[0]), 32'd1);
      @(posedge clock);
      #1;
      send(0, 32'd99, 1'b0, 1'b0);
      wait_idle(0);
      repeat (5) @(posedge clock);
      check("u0.no_leftover", 32'(exp_q[0].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
